typ_cnt_bank: RTL and testbench
===============================

TYP_CNT_BANK -- requirements
Module: typ_cnt_bank

Interface
REQ-001 Parameter TYP SHALL be a type, default byte; it is the element type of every counter, treated as an unsigned packed vector of W = $bits(TYP) bits.
REQ-002 Parameter CH SHALL be an int, default 4; it is the number of independent counter channels, legal range 1..32.
REQ-003 Parameter SAT SHALL be a bit, default 0; 0 selects wrap mode and 1 selects saturate mode, for all channels.
REQ-004 Port clk SHALL be an input, 1 bit: the single system clock, rising-edge active.
REQ-005 Port rst_n SHALL be an input, 1 bit: the asynchronous, active-low reset.
REQ-006 Port en SHALL be an input, CH bits: per-channel count enable.
REQ-007 Port up SHALL be an input, CH bits: per-channel direction, 1 = increment, 0 = decrement.
REQ-008 Port ld SHALL be an input, CH bits: per-channel synchronous load strobe.
REQ-009 Port ld_val SHALL be an input, TYP [CH]: per-channel load value.
REQ-010 Port clr SHALL be an input, CH bits: per-channel clear of the ovf flag.
REQ-011 Port cnt SHALL be an output, TYP [CH]: registered counter values.
REQ-012 Port tc SHALL be an output, CH bits: registered one-cycle terminal-count pulse.
REQ-013 Port ovf SHALL be an output, CH bits: sticky over/underflow flag.
REQ-014 Port siz SHALL be an output, int: constant equal to W.

Function
REQ-015 Per channel, the priority each rising clk edge SHALL be: ld, then en, then hold.
REQ-016 When ld=1, cnt SHALL take ld_val in the next cycle; tc SHALL be 0 and ovf SHALL be unchanged, regardless of en and up.
REQ-017 When en=1 and up=1, the next value SHALL be cnt+1, computed in W+1 bits; a carry out defines overflow.
REQ-018 When en=1 and up=0, the next value SHALL be cnt-1, computed in W+1 bits; a borrow defines underflow.
REQ-019 In wrap mode (SAT=0), overflow SHALL yield 0 and underflow SHALL yield 2^W-1.
REQ-020 In saturate mode (SAT=1), overflow SHALL hold 2^W-1 and underflow SHALL hold 0.
REQ-021 tc SHALL be 1 for exactly the cycle after an edge on which overflow or underflow occurred; otherwise tc SHALL be 0.
REQ-022 In saturate mode, tc SHALL re-pulse on every enabled edge that attempts to pass the limit.
REQ-023 ovf SHALL be set on the edge following an overflow or underflow and SHALL remain set until clr=1.
REQ-024 When clr=1 and an overflow occur on the same edge, ovf SHALL remain 1 (set wins).
REQ-025 The count path SHALL add 1 cycle of latency (input to cnt); there SHALL be no combinational path from inputs to cnt, tc or ovf.
REQ-026 Channels SHALL be fully independent: no input of channel i SHALL affect any output of channel j, for i != j.
REQ-027 For W=1 (TYP=bit), up-counting SHALL toggle 0,1,0 with tc on each return to 0 in wrap mode.

Reset
REQ-028 While rst_n=0, asynchronously: every cnt SHALL be 0, and every tc and ovf SHALL be 0.
REQ-029 Release of rst_n SHALL be synchronous to clk; the first count SHALL occur on the first rising edge with rst_n=1.
REQ-030 Reset asserted mid-count SHALL discard pending ld and clr operations; no tc pulse SHALL survive reset.
REQ-031 siz SHALL equal W at all times, including during reset.

Structure
REQ-032 A package typ_cnt_pkg SHALL hold the mode constants CNT_WRAP=0 and CNT_SAT=1, plus the CH legal-range limits.
REQ-033 One sub-module, typ_cnt_chan (parameters TYP and SAT), SHALL implement a single channel; typ_cnt_bank SHALL generate CH instances of it.
REQ-034 No logic other than instance wiring and the siz assignment SHALL live in typ_cnt_bank.

Verification
REQ-035 With TYP=byte, SAT=0 and ch0 en=1, up=1 from reset: after 256 edges cnt[0]=0, tc[0] pulses once, ovf[0]=1.
REQ-036 With TYP=bit [3:0], SAT=1, ld_val=4'hE, ld then up: cnt goes 14, 15, 15, 15; tc pulses on the 2nd and 3rd holds; ovf=1.
REQ-037 With TYP=int, ch1 up=0 from 0: cnt[1]=32'hFFFF_FFFF and tc[1]=1 for one cycle; siz=32.
REQ-038 With ld=1, en=1 and ld_val=5 on the same edge: cnt=5 and tc=0; then clr with simultaneous overflow leaves ovf=1.
REQ-039 With rst_n dropped mid-count at cnt=7: cnt, tc and ovf go to 0 immediately, with no clk edge; counting resumes at 1 after release.
REQ-040 With TYP=bit and TYP=bit [3:0][3:0]: siz is 1 and 16 respectively, and the other channels are unaffected by driving channel 0.

Source files
------------

// File: rtl/typ_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : typ_cnt_pkg
// Description : Shared constants for the typed counter bank.
//               CNT_WRAP / CNT_SAT select the limit behaviour of every
//               channel. CH_MIN / CH_MAX bound the number of channels a
//               bank may be built with.
// Revision    : 1.0 - initial release
// ============================================================================
package typ_cnt_pkg;

    // Limit behaviour when a count passes 0 or 2^W-1
    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    // Legal range for the number of channels in a bank
    localparam int CH_MIN = 1;
    localparam int CH_MAX = 32;

endpackage : typ_cnt_pkg
`default_nettype wire

// File: rtl/typ_cnt_chan.sv
`default_nettype none
// ============================================================================
// Module      : typ_cnt_chan
// Description : One up/down counter channel of the typed counter bank.
//               Counter width is W = $bits(TYP); the value is handled as an
//               unsigned vector whatever the signedness of TYP.
//               Priority on each clock edge: load, then count, then hold.
//               A carry or borrow out of the W-bit count raises a one-cycle
//               terminal-count pulse and sets a sticky over/underflow flag.
// Ports       : clk       - system clock, rising edge
//               rst_n     - asynchronous active-low reset
//               i_en      - count enable
//               i_up      - direction, 1 = increment, 0 = decrement
//               i_ld      - synchronous load strobe
//               i_ld_val  - load value
//               i_clr     - clear of the sticky flag
//               o_cnt     - registered counter value
//               o_tc      - registered terminal-count pulse
//               o_ovf     - sticky over/underflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module typ_cnt_chan
    import typ_cnt_pkg::*;
#(
    parameter type TYP = byte,
    parameter bit  SAT = CNT_WRAP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_up,
    input  logic i_ld,
    input  TYP   i_ld_val,
    input  logic i_clr,
    output TYP   o_cnt,
    output logic o_tc,
    output logic o_ovf
);

    localparam int W = $bits(TYP);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         tc_q;
    logic         tc_d;
    logic         ovf_q;
    logic         ovf_d;

    logic [W-1:0] w_ld_val;
    logic [W:0]   w_inc;
    logic [W:0]   w_dec;
    logic [W-1:0] w_step_val;
    logic [W-1:0] w_sat_val;
    logic         w_lim_hit;

    assign w_ld_val = i_ld_val;

    // Both directions are computed one bit wider than the counter so the
    // extra MSB directly carries the carry (increment) or borrow (decrement).
    assign w_inc = {1'b0, cnt_q} + (W+1)'(1);
    assign w_dec = {1'b0, cnt_q} - (W+1)'(1);

    assign w_lim_hit  = i_up ? w_inc[W]     : w_dec[W];
    assign w_step_val = i_up ? w_inc[W-1:0] : w_dec[W-1:0];

    // Saturation clamps to the limit that was being approached
    assign w_sat_val  = i_up ? {W{1'b1}} : {W{1'b0}};

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        // Clear acts on its own; a limit hit on the same edge re-sets the
        // flag below, so set wins over clear.
        ovf_d = ovf_q & ~i_clr;

        if (i_ld) begin
            cnt_d = w_ld_val;
        end else if (i_en) begin
            if (w_lim_hit) begin
                // In wrap mode the truncated W-bit result is already 0 on
                // overflow and all-ones on underflow.
                cnt_d = (SAT == CNT_SAT) ? w_sat_val : w_step_val;
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end else begin
                cnt_d = w_step_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign o_cnt = TYP'(cnt_q);
    assign o_tc  = tc_q;
    assign o_ovf = ovf_q;

endmodule : typ_cnt_chan
`default_nettype wire

// File: rtl/typ_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module      : typ_cnt_bank
// Description : Bank of CH independent typed up/down counters. Each channel
//               is one typ_cnt_chan instance; this level only wires the
//               per-channel slices and reports the counter width on siz.
// Ports       : clk     - system clock, rising edge
//               rst_n   - asynchronous active-low reset
//               en      - per-channel count enable
//               up      - per-channel direction, 1 = increment
//               ld      - per-channel synchronous load strobe
//               ld_val  - per-channel load value
//               clr     - per-channel clear of the sticky flag
//               cnt     - per-channel registered counter value
//               tc      - per-channel one-cycle terminal-count pulse
//               ovf     - per-channel sticky over/underflow flag
//               siz     - constant counter width in bits
// Revision    : 1.0 - initial release
// ============================================================================
module typ_cnt_bank
    import typ_cnt_pkg::*;
#(
    parameter type TYP = byte,
    parameter int  CH  = 4,
    parameter bit  SAT = CNT_WRAP
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] en,
    input  logic [CH-1:0] up,
    input  logic [CH-1:0] ld,
    input  TYP            ld_val [CH],
    input  logic [CH-1:0] clr,
    output TYP            cnt    [CH],
    output logic [CH-1:0] tc,
    output logic [CH-1:0] ovf,
    output int            siz
);

    for (genvar g = 0; g < CH; g++) begin : g_chan
        typ_cnt_chan #(
            .TYP (TYP),
            .SAT (SAT)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (en[g]),
            .i_up     (up[g]),
            .i_ld     (ld[g]),
            .i_ld_val (ld_val[g]),
            .i_clr    (clr[g]),
            .o_cnt    (cnt[g]),
            .o_tc     (tc[g]),
            .o_ovf    (ovf[g])
        );
    end

    assign siz = $bits(TYP);

endmodule : typ_cnt_bank
`default_nettype wire

// File: tb/tb_typ_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_typ_cnt_bank
// Description : Testbench for typ_cnt_bank. Five banks of four channels with
//               different element types and modes share one stimulus
//               stream; an integer reference model predicts every cycle and
//               a monitor compares the banks against the queued predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_typ_cnt_bank;

    typedef bit [3:0]      nib_t;
    typedef bit [3:0][3:0] n16_t;

    // Bank k: element width and saturate flag
    localparam int WK [5] = '{8, 4, 1, 32, 16};
    localparam bit SK [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    logic       clk;
    logic       rst_n;
    logic [3:0] en, up, ld, clr;

    byte  ld_a [4];  byte  cnt_a [4];
    nib_t ld_b [4];  nib_t cnt_b [4];
    bit   ld_c [4];  bit   cnt_c [4];
    int   ld_d [4];  int   cnt_d [4];
    n16_t ld_e [4];  n16_t cnt_e [4];

    logic [3:0] tc_a, tc_b, tc_c, tc_d, tc_e;
    logic [3:0] ovf_a, ovf_b, ovf_c, ovf_d, ovf_e;
    int         siz_a, siz_b, siz_c, siz_d, siz_e;

    typ_cnt_bank #(.TYP(byte),  .CH(4), .SAT(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .ld_val(ld_a),
        .clr(clr), .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a), .siz(siz_a));
    typ_cnt_bank #(.TYP(nib_t), .CH(4), .SAT(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .ld_val(ld_b),
        .clr(clr), .cnt(cnt_b), .tc(tc_b), .ovf(ovf_b), .siz(siz_b));
    typ_cnt_bank #(.TYP(bit),   .CH(4), .SAT(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .ld_val(ld_c),
        .clr(clr), .cnt(cnt_c), .tc(tc_c), .ovf(ovf_c), .siz(siz_c));
    typ_cnt_bank #(.TYP(int),   .CH(4), .SAT(1'b0)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .ld_val(ld_d),
        .clr(clr), .cnt(cnt_d), .tc(tc_d), .ovf(ovf_d), .siz(siz_d));
    typ_cnt_bank #(.TYP(n16_t), .CH(4), .SAT(1'b1)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .ld_val(ld_e),
        .clr(clr), .cnt(cnt_e), .tc(tc_e), .ovf(ovf_e), .siz(siz_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [4:0][3:0][31:0] cnt;
        logic [4:0][3:0]       tc;
        logic [4:0][3:0]       ovf;
    } exp_t;

    exp_t   sb [$];
    int     n_checks = 0;
    int     n_pass   = 0;

    longint m_cnt [5][4];
    bit     m_ovf [5][4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [127:0] act_cnt(input int k);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            case (k)
                0:       v[i*32 +: 32] = {24'b0, cnt_a[i]};
                1:       v[i*32 +: 32] = {28'b0, cnt_b[i]};
                2:       v[i*32 +: 32] = {31'b0, cnt_c[i]};
                3:       v[i*32 +: 32] = cnt_d[i];
                default: v[i*32 +: 32] = {16'b0, cnt_e[i]};
            endcase
        end
        return v;
    endfunction

    function automatic logic [3:0] act_tc(input int k);
        case (k)
            0: return tc_a; 1: return tc_b; 2: return tc_c; 3: return tc_d;
            default: return tc_e;
        endcase
    endfunction

    function automatic logic [3:0] act_ovf(input int k);
        case (k)
            0: return ovf_a; 1: return ovf_b; 2: return ovf_c; 3: return ovf_d;
            default: return ovf_e;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 4; i++) begin
                m_cnt[k][i] = 0;
                m_ovf[k][i] = 1'b0;
            end
    endtask

    // Drive one cycle of stimulus and queue the outcome the model predicts
    // for the following rising edge.
    task automatic step(input logic [3:0] e, input logic [3:0] u, input logic [3:0] l,
                        input logic [3:0] c, input logic [3:0][31:0] lv);
        exp_t x;
        @(negedge clk);
        en = e; up = u; ld = l; clr = c;
        for (int i = 0; i < 4; i++) begin
            ld_a[i] = lv[i][7:0];
            ld_b[i] = lv[i][3:0];
            ld_c[i] = lv[i][0];
            ld_d[i] = lv[i];
            ld_e[i] = lv[i][15:0];
        end
        x = '0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                longint mx;
                longint n;
                bit     t;
                mx = (longint'(1) << WK[k]) - 1;
                t  = 1'b0;
                n  = m_cnt[k][i];
                if (l[i]) begin
                    n = longint'(lv[i]) & mx;
                end else if (e[i]) begin
                    n = u[i] ? m_cnt[k][i] + 1 : m_cnt[k][i] - 1;
                    if (n > mx || n < 0) begin
                        t = 1'b1;
                        if (SK[k]) n = u[i] ? mx : 0;
                        else       n = u[i] ? 0  : mx;
                    end
                end
                m_cnt[k][i] = n;
                m_ovf[k][i] = t | (m_ovf[k][i] & ~c[i]);
                x.cnt[k][i] = n[31:0];
                x.tc[k][i]  = t;
                x.ovf[k][i] = m_ovf[k][i];
            end
        end
        sb.push_back(x);
    endtask

    // Monitor: outputs are valid every cycle out of reset
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (rst_n && sb.size() != 0) begin
            x = sb.pop_front();
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("cnt bank%0d", k), act_cnt(k), x.cnt[k]);
                chk($sformatf("tc bank%0d", k), {124'b0, act_tc(k)}, {124'b0, x.tc[k]});
                chk($sformatf("ovf bank%0d", k), {124'b0, act_ovf(k)}, {124'b0, x.ovf[k]});
            end
        end
    end

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
        #2;
        chk("scoreboard drained", 128'(sb.size()), 128'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s cnt bank%0d", tag, k), act_cnt(k), 128'd0);
            chk($sformatf("%s tc bank%0d", tag, k), {124'b0, act_tc(k)}, 128'd0);
            chk($sformatf("%s ovf bank%0d", tag, k), {124'b0, act_ovf(k)}, 128'd0);
        end
    endtask

    function automatic logic [3:0][31:0] rand_lv();
        logic [3:0][31:0] lv;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 4))
                0:       lv[i] = 32'hFFFF_FFFF;
                1:       lv[i] = 32'hFFFF_FFFE;
                2:       lv[i] = 32'd0;
                3:       lv[i] = 32'd1;
                default: lv[i] = $urandom;
            endcase
        end
        return lv;
    endfunction

    // Global time bound
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0][31:0] lv_max;
        logic [3:0][31:0] lv_14;
        logic [3:0][31:0] lv_5;
        lv_max = {4{32'hFFFF_FFFF}};
        lv_14  = {4{32'd14}};
        lv_5   = {4{32'd5}};

        rst_n = 1'b0;
        en = '0; up = '0; ld = '0; clr = '0;
        for (int i = 0; i < 4; i++) begin
            ld_a[i] = '0; ld_b[i] = '0; ld_c[i] = '0; ld_d[i] = '0; ld_e[i] = '0;
        end
        model_reset();

        // Reset state and width reporting while held in reset
        #12;
        chk_all_zero("reset");
        chk("siz byte",   128'(siz_a), 128'd8);
        chk("siz nib",    128'(siz_b), 128'd4);
        chk("siz bit",    128'(siz_c), 128'd1);
        chk("siz int",    128'(siz_d), 128'd32);
        chk("siz n16",    128'(siz_e), 128'd16);
        @(negedge clk);
        rst_n = 1'b1;

        // Count up 256 edges: byte wraps once, nibble saturates, bit toggles
        for (int n = 0; n < 256; n++) step(4'hF, 4'hF, 4'h0, 4'h0, '0);

        // Load 14 then count up: saturating nibble goes 14, 15, 15, 15
        step(4'hF, 4'hF, 4'hF, 4'h0, lv_14);
        for (int n = 0; n < 3; n++) step(4'hF, 4'hF, 4'h0, 4'h0, '0);

        // Load 0 then count down: underflow on every bank
        step(4'h0, 4'h0, 4'hF, 4'hF, '0);
        step(4'hF, 4'h0, 4'h0, 4'h0, '0);
        step(4'h0, 4'h0, 4'h0, 4'h0, '0);

        // Load beats count on the same edge, then clear with overflow
        step(4'hF, 4'hF, 4'hF, 4'h0, lv_5);
        step(4'h0, 4'h0, 4'hF, 4'hF, lv_max);
        step(4'hF, 4'hF, 4'h0, 4'hF, '0);
        step(4'h0, 4'h0, 4'h0, 4'hF, '0);

        // Channel isolation: only channel 0 active
        for (int n = 0; n < 20; n++) step(4'h1, 4'h1, 4'h0, 4'h0, '0);

        // Count to 7, then asynchronous reset between clock edges
        step(4'h0, 4'h0, 4'hF, 4'hF, '0);
        for (int n = 0; n < 7; n++) step(4'hF, 4'hF, 4'h0, 4'h0, '0);
        drain();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        ld = 4'hF; clr = 4'hF; en = 4'hF; up = 4'hF;
        @(negedge clk);
        en = '0; up = '0; ld = '0; clr = '0;
        rst_n = 1'b1;
        model_reset();
        step(4'hF, 4'hF, 4'h0, 4'h0, '0);
        step(4'h0, 4'h0, 4'h0, 4'h0, '0);

        // Randomized traffic with a direction bias that flips periodically
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] e, u, l, c;
            bit         bias_up;
            bias_up = ((n / 64) % 2) == 0;
            for (int i = 0; i < 4; i++) begin
                e[i] = $urandom_range(0, 3) != 0;
                u[i] = bias_up ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
                l[i] = $urandom_range(0, 15) == 0;
                c[i] = $urandom_range(0, 15) == 0;
            end
            step(e, u, l, c, rand_lv());
        end

        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_typ_cnt_bank
`default_nettype wire
